// File: rtl/i2c_multi_address_matcher.sv
// I2C slave address matcher with NUM_ADDR run-time slots, each either 7-bit or
// 10-bit. An optional general-call match is also supported. The slot table is
// captured when a transfer starts, so later table changes have no effect on it.
// The matcher tracks candidates bit by bit and drives the one-bit ACK request.
// It reports the lowest matching slot index and the R/W direction.
//
// Handshake: an event is scl_neg_edge_detected_i & en_i, and it carries one
// SDA bit, MSB first. When en_i is low, the edge pulse is ignored. Dropping
// transfer_in_progress_i returns the block to IDLE on the next clock edge,
// and this takes priority over any event seen in the same cycle.
module i2c_multi_address_matcher #(
    parameter int NUM_ADDR        = 2,
    parameter bit GENERAL_CALL_EN = 1'b1,
    parameter int IDX_W           = 3
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   en_i,
    input  logic                   sda_i,
    input  logic                   transfer_in_progress_i,
    input  logic                   scl_neg_edge_detected_i,
    input  logic [NUM_ADDR*10-1:0] addr_table_i,
    input  logic [NUM_ADDR-1:0]    addr_mode_i,
    input  logic [NUM_ADDR-1:0]    slot_en_i,
    output logic                   address_match_o,
    output logic                   address_match_ack_o,
    output logic                   transfer_type_o,
    output logic [IDX_W-1:0]       match_index_o,
    output logic                   general_call_o
);

    typedef enum logic [2:0] {IDLE, BYTE1, ACK1, BYTE2, DONE} state_t;

    state_t                 state_q, state_d;
    logic [2:0]             bitcnt_q, bitcnt_d;
    logic [NUM_ADDR*10-1:0] addr_q, addr_d;
    logic [NUM_ADDR-1:0]    mode_q, mode_d;
    logic [NUM_ADDR-1:0]    cand_q, cand_d;
    logic                   gc_cand_q, gc_cand_d;
    logic                   match_q, match_d;
    logic                   ack_q, ack_d;
    logic                   type_q, type_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic                   gc_q, gc_d;

    logic                   ev;
    logic [NUM_ADDR-1:0]    hit1, hit2, c7, c10;

    assign ev  = scl_neg_edge_detected_i & en_i;
    assign c7  = cand_q & ~mode_q;
    assign c10 = cand_q & mode_q;

    // Lowest set bit of a slot vector. Duplicate addresses resolve to the lowest slot.
    function automatic logic [IDX_W-1:0] lowest(input logic [NUM_ADDR-1:0] v);
        logic [IDX_W-1:0] r;
        r = '0;
        for (int i = NUM_ADDR - 1; i >= 0; i--)
            if (v[i]) r = IDX_W'(i);
        return r;
    endfunction

    // Per-slot compare of the current SDA bit. In byte 1, a 10-bit slot
    // compares against its 11110xx header. In byte 2, the slot compares
    // against its low address byte.
    always_comb begin
        logic [7:0] pat;
        logic [7:0] lo;
        hit1 = '0;
        hit2 = '0;
        pat  = '0;
        lo   = '0;
        for (int i = 0; i < NUM_ADDR; i++) begin
            pat = mode_q[i] ? {5'b11110, addr_q[i*10+8 +: 2], 1'b0}
                            : {addr_q[i*10 +: 7], 1'b0};
            lo  = addr_q[i*10 +: 8];
            hit1[i] = (pat[3'd7 - bitcnt_q] == sda_i);
            hit2[i] = (lo[3'd7 - bitcnt_q] == sda_i);
        end
    end

    // Next-state and output decode for the address FSM.
    always_comb begin
        state_d   = state_q;
        bitcnt_d  = bitcnt_q;
        addr_d    = addr_q;
        mode_d    = mode_q;
        cand_d    = cand_q;
        gc_cand_d = gc_cand_q;
        match_d   = match_q;
        ack_d     = ack_q;
        type_d    = type_q;
        idx_d     = idx_q;
        gc_d      = gc_q;

        if (!transfer_in_progress_i) begin
            state_d  = IDLE;
            bitcnt_d = '0;
            match_d  = 1'b1;
            ack_d    = 1'b0;
            type_d   = 1'b1;
            idx_d    = '0;
            gc_d     = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    addr_d    = addr_table_i;
                    mode_d    = addr_mode_i;
                    cand_d    = slot_en_i;
                    gc_cand_d = GENERAL_CALL_EN;
                    bitcnt_d  = '0;
                    state_d   = BYTE1;
                end
                BYTE1: if (ev) begin
                    if (bitcnt_q != 3'd7) begin
                        cand_d    = cand_q & hit1;
                        gc_cand_d = gc_cand_q & ~sda_i;
                        match_d   = (|(cand_q & hit1)) | (gc_cand_q & ~sda_i);
                        bitcnt_d  = bitcnt_q + 3'd1;
                    end else begin
                        // R/W bit: a 7-bit match wins over general call,
                        // and general call wins over a pending 10-bit header.
                        type_d  = sda_i;
                        state_d = DONE;
                        if (|c7) begin
                            ack_d = 1'b1;
                            idx_d = lowest(c7);
                        end else if (gc_cand_q && !sda_i) begin
                            ack_d = 1'b1;
                            gc_d  = 1'b1;
                            idx_d = '0;
                        end else if ((|c10) && !sda_i) begin
                            ack_d   = 1'b1;
                            cand_d  = c10;
                            state_d = ACK1;
                        end else begin
                            match_d = 1'b0;
                        end
                    end
                end
                ACK1: if (ev) begin
                    ack_d    = 1'b0;
                    bitcnt_d = '0;
                    state_d  = BYTE2;
                end
                BYTE2: if (ev) begin
                    cand_d = cand_q & hit2;
                    if (bitcnt_q != 3'd7) begin
                        match_d  = |(cand_q & hit2);
                        bitcnt_d = bitcnt_q + 3'd1;
                    end else begin
                        state_d = DONE;
                        if (|(cand_q & hit2)) begin
                            ack_d = 1'b1;
                            idx_d = lowest(cand_q & hit2);
                        end else begin
                            match_d = 1'b0;
                        end
                    end
                end
                DONE: if (ev) ack_d = 1'b0;
                default: state_d = IDLE;
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= IDLE;
            bitcnt_q  <= '0;
            addr_q    <= '0;
            mode_q    <= '0;
            cand_q    <= '0;
            gc_cand_q <= 1'b0;
            match_q   <= 1'b1;
            ack_q     <= 1'b0;
            type_q    <= 1'b1;
            idx_q     <= '0;
            gc_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            bitcnt_q  <= bitcnt_d;
            addr_q    <= addr_d;
            mode_q    <= mode_d;
            cand_q    <= cand_d;
            gc_cand_q <= gc_cand_d;
            match_q   <= match_d;
            ack_q     <= ack_d;
            type_q    <= type_d;
            idx_q     <= idx_d;
            gc_q      <= gc_d;
        end
    end

    assign address_match_o     = match_q;
    assign address_match_ack_o = ack_q;
    assign transfer_type_o     = type_q;
    assign match_index_o       = idx_q;
    assign general_call_o      = gc_q;

endmodule

// File: tb/tb_i2c_multi_address_matcher.sv
// Directed bench for i2c_multi_address_matcher (2 slots, general call enabled).
module tb_i2c_multi_address_matcher;

    logic        clk_i = 1'b0;
    logic        reset_i = 1'b1;
    logic        en_i = 1'b0;
    logic        sda_i = 1'b0;
    logic        tip = 1'b0;
    logic        scl_ev = 1'b0;
    logic [19:0] addr_table = '0;
    logic [1:0]  addr_mode = '0;
    logic [1:0]  slot_en = '0;
    logic        match_o, ack_o, type_o, gc_o;
    logic [2:0]  idx_o;

    int n_checks = 0;
    int n_fail = 0;

    i2c_multi_address_matcher #(.NUM_ADDR(2), .GENERAL_CALL_EN(1'b1), .IDX_W(3)) dut (
        .clk_i(clk_i), .reset_i(reset_i), .en_i(en_i), .sda_i(sda_i),
        .transfer_in_progress_i(tip), .scl_neg_edge_detected_i(scl_ev),
        .addr_table_i(addr_table), .addr_mode_i(addr_mode), .slot_en_i(slot_en),
        .address_match_o(match_o), .address_match_ack_o(ack_o),
        .transfer_type_o(type_o), .match_index_o(idx_o), .general_call_o(gc_o)
    );

    always #5 clk_i = ~clk_i;

    // One SCL falling-edge pulse carrying bit b; outputs are sampled at the following negedge.
    task automatic send_bit(input logic b, input logic en);
        @(negedge clk_i);
        sda_i = b; en_i = en; scl_ev = 1'b1;
        @(negedge clk_i);
        scl_ev = 1'b0; en_i = 1'b0;
    endtask

    task automatic send_bits(input logic [7:0] b, input int n);
        for (int i = 0; i < n; i++) send_bit(b[7-i], 1'b1);
    endtask

    task automatic start_xfer();
        tip = 1'b1;
        repeat (2) @(negedge clk_i);
    endtask

    task automatic end_xfer();
        tip = 1'b0;
        repeat (2) @(negedge clk_i);
    endtask

    task automatic test_reset();
        n_checks++; if (match_o !== 1'b1) begin n_fail++; $display("FAIL reset_match got %b exp 1", match_o); end
        n_checks++; if (ack_o !== 1'b0) begin n_fail++; $display("FAIL reset_ack got %b exp 0", ack_o); end
        n_checks++; if (type_o !== 1'b1) begin n_fail++; $display("FAIL reset_type got %b exp 1", type_o); end
        n_checks++; if (idx_o !== 3'd0) begin n_fail++; $display("FAIL reset_idx got %0d exp 0", idx_o); end
        n_checks++; if (gc_o !== 1'b0) begin n_fail++; $display("FAIL reset_gc got %b exp 0", gc_o); end
    endtask

    task automatic test_seven_bit();
        addr_table = {10'h000, 10'h020}; addr_mode = 2'b00; slot_en = 2'b01;
        start_xfer();
        send_bits(8'h40, 7);
        n_checks++; if (ack_o !== 1'b0) begin n_fail++; $display("FAIL s7_ack_early got %b exp 0", ack_o); end
        send_bit(1'b0, 1'b1);
        n_checks++; if (ack_o !== 1'b1) begin n_fail++; $display("FAIL s7_ack got %b exp 1", ack_o); end
        n_checks++; if (idx_o !== 3'd0) begin n_fail++; $display("FAIL s7_idx got %0d exp 0", idx_o); end
        n_checks++; if (type_o !== 1'b0) begin n_fail++; $display("FAIL s7_type got %b exp 0", type_o); end
        n_checks++; if (match_o !== 1'b1) begin n_fail++; $display("FAIL s7_match got %b exp 1", match_o); end
        send_bit(1'b0, 1'b1);
        n_checks++; if (ack_o !== 1'b0) begin n_fail++; $display("FAIL s7_ack_clear got %b exp 0", ack_o); end
        send_bits(8'hFF, 8);
        n_checks++; if (ack_o !== 1'b0 || match_o !== 1'b1) begin n_fail++; $display("FAIL s7_done_ignore got ack %b match %b exp 0 1", ack_o, match_o); end
        end_xfer();
        n_checks++; if (type_o !== 1'b1) begin n_fail++; $display("FAIL s7_idle_type got %b exp 1", type_o); end
        start_xfer();
        send_bits(8'h41, 8);
        n_checks++; if (ack_o !== 1'b1 || type_o !== 1'b1) begin n_fail++; $display("FAIL s7_read got ack %b type %b exp 1 1", ack_o, type_o); end
        end_xfer();
    endtask

    task automatic test_two_slots();
        addr_table = {10'h031, 10'h020}; addr_mode = 2'b00; slot_en = 2'b11;
        start_xfer();
        send_bits(8'h62, 8);
        n_checks++; if (ack_o !== 1'b1) begin n_fail++; $display("FAIL two_ack got %b exp 1", ack_o); end
        n_checks++; if (idx_o !== 3'd1) begin n_fail++; $display("FAIL two_idx got %0d exp 1", idx_o); end
        n_checks++; if (type_o !== 1'b0) begin n_fail++; $display("FAIL two_type got %b exp 0", type_o); end
        end_xfer();
        start_xfer();
        send_bits(8'h50, 3);
        n_checks++; if (match_o !== 1'b1) begin n_fail++; $display("FAIL two_match_b3 got %b exp 1", match_o); end
        send_bit(1'b1, 1'b1);
        n_checks++; if (match_o !== 1'b0) begin n_fail++; $display("FAIL two_match_b4 got %b exp 0", match_o); end
        send_bits(8'h00, 4);
        n_checks++; if (ack_o !== 1'b0 || match_o !== 1'b0) begin n_fail++; $display("FAIL two_nomatch got ack %b match %b exp 0 0", ack_o, match_o); end
        end_xfer();
    endtask

    task automatic test_ten_bit();
        addr_table = {10'h2A5, 10'h020}; addr_mode = 2'b10; slot_en = 2'b11;
        start_xfer();
        send_bits(8'hF4, 8);
        n_checks++; if (ack_o !== 1'b1 || match_o !== 1'b1) begin n_fail++; $display("FAIL ten_hdr got ack %b match %b exp 1 1", ack_o, match_o); end
        send_bit(1'b0, 1'b1);
        n_checks++; if (ack_o !== 1'b0) begin n_fail++; $display("FAIL ten_ack1_clear got %b exp 0", ack_o); end
        send_bits(8'hA5, 8);
        n_checks++; if (ack_o !== 1'b1) begin n_fail++; $display("FAIL ten_ack got %b exp 1", ack_o); end
        n_checks++; if (idx_o !== 3'd1) begin n_fail++; $display("FAIL ten_idx got %0d exp 1", idx_o); end
        n_checks++; if (type_o !== 1'b0) begin n_fail++; $display("FAIL ten_type got %b exp 0", type_o); end
        end_xfer();
        start_xfer();
        send_bits(8'hF4, 8);
        send_bit(1'b0, 1'b1);
        send_bits(8'hA4, 8);
        n_checks++; if (ack_o !== 1'b0 || match_o !== 1'b0) begin n_fail++; $display("FAIL ten_miss got ack %b match %b exp 0 0", ack_o, match_o); end
        end_xfer();
    endtask

    task automatic test_general_call();
        addr_table = {10'h031, 10'h020}; addr_mode = 2'b00; slot_en = 2'b00;
        start_xfer();
        send_bit(1'b0, 1'b1);
        n_checks++; if (match_o !== 1'b1) begin n_fail++; $display("FAIL gc_match_b1 got %b exp 1", match_o); end
        send_bits(8'h00, 7);
        n_checks++; if (ack_o !== 1'b1 || gc_o !== 1'b1) begin n_fail++; $display("FAIL gc_ack got ack %b gc %b exp 1 1", ack_o, gc_o); end
        n_checks++; if (type_o !== 1'b0) begin n_fail++; $display("FAIL gc_type got %b exp 0", type_o); end
        end_xfer();
        start_xfer();
        send_bits(8'h01, 8);
        n_checks++; if (ack_o !== 1'b0 || gc_o !== 1'b0 || match_o !== 1'b0) begin n_fail++; $display("FAIL gc_read got ack %b gc %b match %b exp 0 0 0", ack_o, gc_o, match_o); end
        n_checks++; if (type_o !== 1'b1) begin n_fail++; $display("FAIL gc_read_type got %b exp 1", type_o); end
        end_xfer();
    endtask

    task automatic test_abort_and_reset();
        addr_table = {10'h000, 10'h020}; addr_mode = 2'b00; slot_en = 2'b01;
        start_xfer();
        send_bits(8'h40, 4);
        end_xfer();
        start_xfer();
        send_bits(8'h40, 8);
        n_checks++; if (ack_o !== 1'b1 || idx_o !== 3'd0 || type_o !== 1'b0) begin n_fail++; $display("FAIL abort_rematch got ack %b idx %0d type %b exp 1 0 0", ack_o, idx_o, type_o); end
        #2 reset_i = 1'b1;
        #1;
        n_checks++; if (ack_o !== 1'b0 || match_o !== 1'b1 || type_o !== 1'b1) begin n_fail++; $display("FAIL async_reset got ack %b match %b type %b exp 0 1 1", ack_o, match_o, type_o); end
        @(negedge clk_i);
        reset_i = 1'b0;
        end_xfer();
    endtask

    task automatic test_robustness();
        logic [7:0] b;
        b = 8'h62;
        addr_table = {10'h031, 10'h020}; addr_mode = 2'b00; slot_en = 2'b11;
        start_xfer();
        for (int i = 0; i < 8; i++) begin
            addr_table = ~addr_table;
            send_bit(~b[7-i], 1'b0);
            send_bit(b[7-i], 1'b1);
        end
        n_checks++; if (ack_o !== 1'b1 || idx_o !== 3'd1 || type_o !== 1'b0) begin n_fail++; $display("FAIL robust got ack %b idx %0d type %b exp 1 1 0", ack_o, idx_o, type_o); end
        end_xfer();
    endtask

    initial begin
        repeat (2) @(negedge clk_i);
        test_reset();
        reset_i = 1'b0;
        @(negedge clk_i);
        test_seven_bit();
        test_two_slots();
        test_ten_bit();
        test_general_call();
        test_abort_and_reset();
        test_robustness();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
